// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback request, regfile write and bypass signals of the writeback arbiter
`ifndef REG_BUS_WIDTH
`define REG_BUS_WIDTH 5
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

interface rf_wb_arbiter_if;
   logic                         ex_wb_vld_i;
   logic [`REG_BUS_WIDTH-1:0]    ex_wb_waddr_i;
   logic [`DATA_BUS_WIDTH-1:0]   ex_wb_wdata_i;
   logic                         ex_wb_rdy_o;
   logic                         lsu_wb_vld_i;
   logic [`REG_BUS_WIDTH-1:0]    lsu_wb_waddr_i;
   logic [`DATA_BUS_WIDTH-1:0]   lsu_wb_wdata_i;
   logic                         lsu_wb_rdy_o;
   logic [`REG_BUS_WIDTH-1:0]    reg_waddr_o;
   logic                         reg_waddr_vld_o;
   logic [`DATA_BUS_WIDTH-1:0]   reg_wdata_o;
   logic [`REG_BUS_WIDTH-1:0]    fwd_raddr1_i;
   logic [`REG_BUS_WIDTH-1:0]    fwd_raddr2_i;
   logic                         fwd_hit1_o;
   logic                         fwd_hit2_o;
   logic [`DATA_BUS_WIDTH-1:0]   fwd_data_o;

   // Arbiter side
   modport slave (
      input  ex_wb_vld_i, ex_wb_waddr_i, ex_wb_wdata_i,
      input  lsu_wb_vld_i, lsu_wb_waddr_i, lsu_wb_wdata_i,
      input  fwd_raddr1_i, fwd_raddr2_i,
      output ex_wb_rdy_o, lsu_wb_rdy_o,
      output reg_waddr_o, reg_waddr_vld_o, reg_wdata_o,
      output fwd_hit1_o, fwd_hit2_o, fwd_data_o
   );

   // Requester / regfile / decode side
   modport master (
      output ex_wb_vld_i, ex_wb_waddr_i, ex_wb_wdata_i,
      output lsu_wb_vld_i, lsu_wb_waddr_i, lsu_wb_wdata_i,
      output fwd_raddr1_i, fwd_raddr2_i,
      input  ex_wb_rdy_o, lsu_wb_rdy_o,
      input  reg_waddr_o, reg_waddr_vld_o, reg_wdata_o,
      input  fwd_hit1_o, fwd_hit2_o, fwd_data_o
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-source regfile writeback arbiter (LSU priority, EX anti-starvation) with bypass
`ifndef REG_BUS_WIDTH
`define REG_BUS_WIDTH 5
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module rf_wb_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   rf_wb_arbiter_if.slave    bus
);
   localparam int RW = `REG_BUS_WIDTH;
   localparam int DW = `DATA_BUS_WIDTH;

   logic [3:0]    starve_cnt;
   logic          ex_force;
   logic          ex_gnt;
   logic          lsu_gnt;
   logic [RW-1:0] win_addr;
   logic [DW-1:0] win_data;

   logic          wr_vld;
   logic [RW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   // Grants depend only on valids, reset and the starvation count, never on data
   always_comb begin
      ex_force = bus.ex_wb_vld_i && (starve_cnt >= 4'(STARVE_MAX));
      lsu_gnt  = rst_n_i && bus.lsu_wb_vld_i && !ex_force;
      ex_gnt   = rst_n_i && bus.ex_wb_vld_i && (ex_force || !bus.lsu_wb_vld_i);
      win_addr = ex_gnt ? bus.ex_wb_waddr_i : bus.lsu_wb_waddr_i;
      win_data = ex_gnt ? bus.ex_wb_wdata_i : bus.lsu_wb_wdata_i;
   end

   assign bus.ex_wb_rdy_o  = ex_gnt;
   assign bus.lsu_wb_rdy_o = lsu_gnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         starve_cnt <= 4'd0;
      end else if (!bus.ex_wb_vld_i || ex_gnt) begin
         starve_cnt <= 4'd0;
      end else if (lsu_gnt) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // x0 writes are consumed without touching the output stage
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_vld  <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if ((ex_gnt || lsu_gnt) && (win_addr != '0)) begin
         wr_vld  <= 1'b1;
         wr_addr <= win_addr;
         wr_data <= win_data;
      end else begin
         wr_vld  <= 1'b0;
      end
   end

   assign bus.reg_waddr_vld_o = wr_vld;
   assign bus.reg_waddr_o     = wr_addr;
   assign bus.reg_wdata_o     = wr_data;
   assign bus.fwd_data_o      = wr_data;
   assign bus.fwd_hit1_o      = wr_vld && (bus.fwd_raddr1_i == wr_addr) && (bus.fwd_raddr1_i != '0);
   assign bus.fwd_hit2_o      = wr_vld && (bus.fwd_raddr2_i == wr_addr) && (bus.fwd_raddr2_i != '0);
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the maximum consecutive LSU grants allowed while EX waits (legal range 1..15).
REQ-002 Widths SHALL come from `REG_BUS_WIDTH (register address, 5) and `DATA_BUS_WIDTH (data, 32) in param.v.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 ex_wb_vld_i  input  1  EX writeback request valid.
REQ-006 ex_wb_waddr_i  input  REG  EX destination register.
REQ-007 ex_wb_wdata_i  input  DATA  EX writeback data.
REQ-008 ex_wb_rdy_o  output  1  EX request accepted this cycle.
REQ-009 lsu_wb_vld_i / lsu_wb_waddr_i / lsu_wb_wdata_i  input  1/REG/DATA  LSU load-return request; same semantics as EX.
REQ-010 lsu_wb_rdy_o  output  1  LSU request accepted this cycle.
REQ-011 reg_waddr_o  output  REG  to regfile reg_waddr_i.
REQ-012 reg_waddr_vld_o  output  1  to regfile reg_waddr_vld_i.
REQ-013 reg_wdata_o  output  DATA  to regfile reg_wdata_i.
REQ-014 fwd_raddr1_i / fwd_raddr2_i  input  REG  decode read addresses for bypass.
REQ-015 fwd_hit1_o / fwd_hit2_o  output  1  read address matches the pending (registered) write.
REQ-016 fwd_data_o  output  DATA  pending write data (equals reg_wdata_o).

Function
REQ-017 Handshake: a transfer occurs when vld_i and rdy_o are both 1; source SHALL hold vld/waddr/wdata stable until transfer; rdy_o SHALL be combinational from vld inputs and arbiter state only (never from wdata).
REQ-018 At most one requester SHALL be granted per cycle; an ungranted requester's rdy_o SHALL be 0.
REQ-019 Default priority: LSU over EX.
REQ-020 Starvation counter starve_cnt (4 bits): increments on each cycle LSU is granted while ex_wb_vld_i=1; resets to 0 on any EX grant or any cycle ex_wb_vld_i=0.
REQ-021 When starve_cnt == STARVE_MAX and ex_wb_vld_i=1, EX SHALL be granted regardless of LSU; counter then returns to 0.
REQ-022 A sole valid requester SHALL be granted in the same cycle (no idle bubble).
REQ-023 Output stage: on a transfer, waddr/wdata SHALL be registered; reg_waddr_vld_o SHALL be 1 in the following cycle for exactly one cycle per transfer (latency 1); with no transfer reg_waddr_vld_o SHALL be 0 next cycle.
REQ-024 Writes to x0 (waddr==0) SHALL be accepted (rdy_o=1) but SHALL NOT raise reg_waddr_vld_o; reg_waddr_o/reg_wdata_o hold previous values.
REQ-025 Back-to-back transfers on consecutive cycles SHALL be supported at full throughput (one write per cycle).
REQ-026 fwd_hitN_o SHALL be 1 iff reg_waddr_vld_o=1, fwd_raddrN_i==reg_waddr_o and fwd_raddrN_i!=0; fwd_data_o = reg_wdata_o.
REQ-027 Same waddr from both requesters in one cycle: write order SHALL equal grant order; the later grant's value is the final regfile content.
REQ-028 reg_waddr_o and reg_wdata_o SHALL only change on a transfer with waddr!=0.

Reset
REQ-029 On rst_n_i=0 (any time, including mid-stream): reg_waddr_vld_o=0, reg_waddr_o=0, reg_wdata_o=0, starve_cnt=0, fwd_hit1_o=fwd_hit2_o=0; the in-flight registered write SHALL be discarded.
REQ-030 While rst_n_i=0, ex_wb_rdy_o and lsu_wb_rdy_o SHALL be 0.
REQ-031 First grant possible in the first cycle after rst_n_i deasserts.

Verification
REQ-032 EX only, vld with waddr=5, wdata=0xDEADBEEF -> ex_wb_rdy_o=1 same cycle; next cycle reg_waddr_vld_o=1, reg_waddr_o=5, reg_wdata_o=0xDEADBEEF, then 0.
REQ-033 Both valid continuously, STARVE_MAX=4 -> grant sequence LSU,LSU,LSU,LSU,EX, repeating; reg_waddr_vld_o=1 every cycle.
REQ-034 LSU waddr=0 wdata=0x1 -> lsu_wb_rdy_o=1, reg_waddr_vld_o stays 0, reg_waddr_o/reg_wdata_o unchanged.
REQ-035 Both valid, both waddr=7, EX=0x11, LSU=0x22 -> LSU write of 0x22 then EX write of 0x11 on consecutive cycles; x7 reads 0x11.
REQ-036 Pending write waddr=3 data=0xA5, fwd_raddr1_i=3, fwd_raddr2_i=0 -> fwd_hit1_o=1, fwd_hit2_o=0, fwd_data_o=0xA5.
REQ-037 Assert rst_n_i=0 asynchronously while reg_waddr_vld_o=1 -> reg_waddr_vld_o, reg_waddr_o, reg_wdata_o, both rdy_o go 0 immediately; starve_cnt=0 after release.
